// File: rtl/mac_pkg.sv
// Shared definitions for the MAC dot-product sequencer: state encoding,
// default operand widths and the packing of the (a, b) element stream.
package mac_pkg;

   localparam int MAC_A_W   = 8;
   localparam int MAC_B_W   = 8;
   localparam int MAC_ACC_W = 32;

   // b sits in the low bits of s_axis_ab_tdata, a directly above it.
   localparam int AB_B_LSB = 0;

   function automatic int ab_a_lsb(input int b_w);
      return AB_B_LSB + b_w;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_OUTPUT = 3'd4,
      ST_ERROR  = 3'd5
   } seq_state_e;

endpackage

// File: rtl/mac_watchdog.sv
// Load/enable cycle counter; expire is raised in the enabled cycle that
// completes TIMEOUT enabled cycles since the last load.
module mac_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt_q;

   assign expire = en && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= '0;
      end else if (en && !expire) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Drives an external a*b+c MAC one operation at a time to form a signed dot
// product of vec_len element pairs. Optional watchdog: MAC_WATCHDOG_EN.
module mac_dot_sequencer
   import mac_pkg::*;
#(
   parameter int A_W   = MAC_A_W,
   parameter int B_W   = MAC_B_W,
   parameter int ACC_W = MAC_ACC_W,
   parameter int LEN_W = 8
`ifdef MAC_WATCHDOG_EN
   ,
   parameter int TIMEOUT = 64
`endif
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               start,
   input  logic [LEN_W-1:0]   vec_len,
   input  logic [ACC_W-1:0]   c_init,
   input  logic               s_axis_ab_tvalid,
   output logic               s_axis_ab_tready,
   input  logic [A_W+B_W-1:0] s_axis_ab_tdata,
   output logic               mac_a_tvalid,
   output logic               mac_b_tvalid,
   output logic               mac_c_tvalid,
   output logic [A_W-1:0]     mac_a_tdata,
   output logic [B_W-1:0]     mac_b_tdata,
   output logic [ACC_W-1:0]   mac_c_tdata,
   input  logic               mac_result_tvalid,
   input  logic [ACC_W-1:0]   mac_result_tdata,
   output logic               m_axis_dot_tvalid,
   input  logic               m_axis_dot_tready,
   output logic [ACC_W-1:0]   m_axis_dot_tdata,
   output logic               busy,
   output logic               error
);

   localparam int A_LSB = ab_a_lsb(B_W);

   seq_state_e        state_q, state_nxt;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  count_q;
   logic [ACC_W-1:0]  acc_q;
   logic [A_W-1:0]    a_q;
   logic [B_W-1:0]    b_q;
   logic              wd_expire;
   logic              issue;

`ifdef MAC_WATCHDOG_EN
   mac_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (aclk),
      .rst_n  (aresetn),
      .load   (state_q == ST_ISSUE),
      .en     (state_q == ST_WAIT),
      .expire (wd_expire)
   );
   assign error = (state_q == ST_ERROR);
`else
   assign wd_expire = 1'b0;
   assign error     = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt        = state_q;
      s_axis_ab_tready = 1'b0;
      issue            = 1'b0;
      m_axis_dot_tvalid = 1'b0;
      busy             = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = (vec_len == '0) ? ST_OUTPUT : ST_FETCH;
            end
         end
         ST_FETCH: begin
            s_axis_ab_tready = 1'b1;
            if (s_axis_ab_tvalid) begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            issue     = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // A result arriving in the expiry cycle still wins over the watchdog.
            if (mac_result_tvalid) begin
               state_nxt = (count_q + LEN_W'(1) == len_q) ? ST_OUTPUT : ST_FETCH;
            end else if (wd_expire) begin
               state_nxt = ST_ERROR;
            end
         end
         ST_OUTPUT: begin
            m_axis_dot_tvalid = 1'b1;
            if (m_axis_dot_tready) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_ERROR: begin
            state_nxt = ST_ERROR;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // NOTE: the datapath registers are reset too, because their values appear
   // directly on outputs that must read zero out of reset.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         len_q   <= '0;
         count_q <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  len_q   <= vec_len;
                  acc_q   <= c_init;
                  count_q <= '0;
               end
            end
            ST_FETCH: begin
               if (s_axis_ab_tvalid) begin
                  a_q <= s_axis_ab_tdata[A_LSB +: A_W];
                  b_q <= s_axis_ab_tdata[AB_B_LSB +: B_W];
               end
            end
            ST_WAIT: begin
               if (mac_result_tvalid) begin
                  acc_q   <= mac_result_tdata;
                  count_q <= count_q + LEN_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign mac_a_tvalid     = issue;
   assign mac_b_tvalid     = issue;
   assign mac_c_tvalid     = issue;
   assign mac_a_tdata      = a_q;
   assign mac_b_tdata      = b_q;
   assign mac_c_tdata      = acc_q;
   assign m_axis_dot_tdata = acc_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer: table vectors, random dot products
// against an arithmetic model, plus reset, backpressure and stalled-MAC sequences.
module tb_mac_dot_sequencer;

   localparam int A_W   = 8;
   localparam int B_W   = 8;
   localparam int ACC_W = 32;
   localparam int LEN_W = 8;
   localparam int L     = 3;

   logic               aclk    = 1'b0;
   logic               aresetn = 1'b1;
   logic               start;
   logic [LEN_W-1:0]   vec_len;
   logic [ACC_W-1:0]   c_init;
   logic               s_axis_ab_tvalid;
   logic               s_axis_ab_tready;
   logic [A_W+B_W-1:0] s_axis_ab_tdata;
   logic               mac_a_tvalid, mac_b_tvalid, mac_c_tvalid;
   logic [A_W-1:0]     mac_a_tdata;
   logic [B_W-1:0]     mac_b_tdata;
   logic [ACC_W-1:0]   mac_c_tdata;
   logic               mac_result_tvalid;
   logic [ACC_W-1:0]   mac_result_tdata;
   logic               m_axis_dot_tvalid;
   logic               m_axis_dot_tready;
   logic [ACC_W-1:0]   m_axis_dot_tdata;
   logic               busy;
   logic               error;

   always #5 aclk = ~aclk;

   mac_dot_sequencer dut (
      .aclk              (aclk),
      .aresetn           (aresetn),
      .start             (start),
      .vec_len           (vec_len),
      .c_init            (c_init),
      .s_axis_ab_tvalid  (s_axis_ab_tvalid),
      .s_axis_ab_tready  (s_axis_ab_tready),
      .s_axis_ab_tdata   (s_axis_ab_tdata),
      .mac_a_tvalid      (mac_a_tvalid),
      .mac_b_tvalid      (mac_b_tvalid),
      .mac_c_tvalid      (mac_c_tvalid),
      .mac_a_tdata       (mac_a_tdata),
      .mac_b_tdata       (mac_b_tdata),
      .mac_c_tdata       (mac_c_tdata),
      .mac_result_tvalid (mac_result_tvalid),
      .mac_result_tdata  (mac_result_tdata),
      .m_axis_dot_tvalid (m_axis_dot_tvalid),
      .m_axis_dot_tready (m_axis_dot_tready),
      .m_axis_dot_tdata  (m_axis_dot_tdata),
      .busy              (busy),
      .error             (error)
   );

   typedef struct packed {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [31:0] c;
   } op_t;

   typedef struct packed {
      logic [31:0] c_init;
      logic [7:0]  len;
      logic [31:0] a;      // element i in bits [8*i +: 8]
      logic [31:0] b;
      logic [3:0]  gap;
      logic [3:0]  stall;
      logic [31:0] exp;
   } vec_t;

   int         n_checks  = 0;
   int         n_err     = 0;
   int         cyc       = 0;
   int         issue_cnt = 0;
   bit         mac_mute  = 1'b0;
   op_t        exp_ops[$];
   op_t        mon_op;
   logic [7:0] ea[$];
   logic [7:0] eb[$];
   vec_t       vecs[6];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] mac_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [31:0] c);
      int ai, bi;
      ai = $signed(a);
      bi = $signed(b);
      return 32'(ai * bi) + c;
   endfunction

   // MAC model: fixed latency L, never reset, can be muted to emulate a hung MAC.
   logic [L-1:0]     pipe_v = '0;
   logic [ACC_W-1:0] pipe_d[L];

   always @(posedge aclk) begin
      pipe_v    <= {pipe_v[L-2:0], (mac_a_tvalid === 1'b1) && !mac_mute};
      pipe_d[0] <= mac_f(mac_a_tdata, mac_b_tdata, mac_c_tdata);
      for (int i = 1; i < L; i++) pipe_d[i] <= pipe_d[i-1];
      cyc <= cyc + 1;
   end

   assign mac_result_tvalid = pipe_v[L-1];
   assign mac_result_tdata  = pipe_d[L-1];

   always @(negedge aclk) begin
      if ((mac_a_tvalid | mac_b_tvalid | mac_c_tvalid) === 1'b1) begin
         issue_cnt++;
         check("mac_valids_equal", {mac_a_tvalid, mac_b_tvalid, mac_c_tvalid}, 3'b111);
         check("mac_one_outstanding", pipe_v, 0);
         if (exp_ops.size() == 0) begin
            check("unexpected_issue", 1, 0);
         end else begin
            mon_op = exp_ops.pop_front();
            check("mac_operands", {mac_a_tdata, mac_b_tdata, mac_c_tdata},
                  {mon_op.a, mon_op.b, mon_op.c});
         end
      end
   end

   function automatic vec_t mk(input logic [31:0] c, input logic [7:0] len,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] gap, input logic [3:0] stall,
                               input logic [31:0] exp);
      vec_t v;
      v.c_init = c; v.len = len; v.a = a; v.b = b;
      v.gap = gap; v.stall = stall; v.exp = exp;
      return v;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctrl"}, {s_axis_ab_tready, mac_a_tvalid, mac_b_tvalid, mac_c_tvalid,
                             m_axis_dot_tvalid, busy, error}, 0);
      check({tag, "_mac_data"}, {mac_a_tdata, mac_b_tdata, mac_c_tdata}, 0);
      check({tag, "_dot_data"}, m_axis_dot_tdata, 0);
   endtask

   task automatic feed_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                           output bit ok);
      bit hs;
      int budget;
      s_axis_ab_tdata  = {a, b};
      s_axis_ab_tvalid = 1'b1;
      budget = 0;
      do begin
         hs = s_axis_ab_tready;
         @(posedge aclk); #1;
         budget++;
      end while (!hs && budget < 200);
      s_axis_ab_tvalid = 1'b0;
      ok = hs;
      if (!hs) check({tag, "_fetch_timeout"}, 1, 0);
   endtask

   // Elements come from ea/eb; exp_lat < 0 skips the latency comparison.
   task automatic run_dot(input string tag, input logic [31:0] c, input int gap,
                          input int stall, input bit spurious, input logic [31:0] exp,
                          input int exp_lat);
      int          len, cs, budget, ic0;
      logic [31:0] run, held;
      op_t         op;
      bit          ok;
      len = ea.size();
      run = c;
      exp_ops = {};
      for (int i = 0; i < len; i++) begin
         op.a = ea[i]; op.b = eb[i]; op.c = run;
         exp_ops.push_back(op);
         run = mac_f(ea[i], eb[i], run);
      end
      ic0     = issue_cnt;
      vec_len = LEN_W'(len);
      c_init  = c;
      start   = 1'b1;
      cs      = cyc;
      @(posedge aclk); #1;
      if (spurious) begin
         vec_len = '0;
         c_init  = 32'hDEAD_BEEF;
      end else begin
         start = 1'b0;
      end
      for (int i = 0; i < len; i++) begin
         repeat (gap) begin @(posedge aclk); #1; end
         feed_one(tag, ea[i], eb[i], ok);
         if (!ok) begin
            start = 1'b0;
            return;
         end
      end
      start  = 1'b0;
      budget = 0;
      while (!m_axis_dot_tvalid && budget < 2000) begin
         @(posedge aclk); #1;
         budget++;
      end
      if (!m_axis_dot_tvalid) begin
         check({tag, "_dot_timeout"}, 1, 0);
         return;
      end
      if (exp_lat >= 0) check({tag, "_latency"}, 64'(cyc - cs), 64'(exp_lat));
      held = m_axis_dot_tdata;
      check({tag, "_dot"}, held, exp);
      repeat (stall) begin
         @(posedge aclk); #1;
         check({tag, "_stall_stable"}, {m_axis_dot_tvalid, m_axis_dot_tdata}, {1'b1, held});
      end
      m_axis_dot_tready = 1'b1;
      @(posedge aclk); #1;
      m_axis_dot_tready = 1'b0;
      check({tag, "_busy_drop"}, {busy, m_axis_dot_tvalid}, 0);
      check({tag, "_issue_count"}, 64'(issue_cnt - ic0), 64'(len));
      check({tag, "_ops_left"}, 64'(exp_ops.size()), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      start = 1'b0; vec_len = '0; c_init = '0;
      s_axis_ab_tvalid = 1'b0; s_axis_ab_tdata = '0; m_axis_dot_tready = 1'b0;

      #2 aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      check_reset_outputs("reset");
      aresetn = 1'b1;
      repeat (L + 1) @(posedge aclk);
      #1;

      vecs[0] = mk(32'd10, 8'd3, 32'h0001_0402, 32'h0001_0503, 4'd0, 4'd0, 32'd37);
      vecs[1] = mk(32'd0, 8'd1, 32'h0000_00FF, 32'h0000_00FF, 4'd0, 4'd0, 32'h0000_0001);
      vecs[2] = mk(32'h1234, 8'd0, 32'h0, 32'h0, 4'd0, 4'd2, 32'h0000_1234);
      vecs[3] = mk(32'hFFFF_FFFB, 8'd2, 32'h0000_7F80, 32'h0000_7F7F, 4'd4, 4'd5, 32'hFFFF_FF7C);
      vecs[4] = mk(32'h7FFF_FFFF, 8'd1, 32'h0000_0001, 32'h0000_0001, 4'd0, 4'd1, 32'h8000_0000);
      vecs[5] = mk(32'd0, 8'd4, 32'h6403_FEFF, 32'h64FD_0302, 4'd0, 4'd0, 32'h0000_26FF);

      for (int v = 0; v < 6; v++) begin
         ea = {}; eb = {};
         for (int i = 0; i < int'(vecs[v].len); i++) begin
            ea.push_back(vecs[v].a[8*i +: 8]);
            eb.push_back(vecs[v].b[8*i +: 8]);
         end
         run_dot($sformatf("vec%0d", v), vecs[v].c_init, int'(vecs[v].gap),
                 int'(vecs[v].stall), vecs[v].gap != 0, vecs[v].exp,
                 (vecs[v].gap == 0) ? 1 + int'(vecs[v].len) * (L + 2) : -1);
      end

      for (int r = 0; r < 8; r++) begin
         longint      acc;
         int          len, gap, ai, bi;
         logic [31:0] c;
         len = int'($urandom_range(1, 6));
         gap = int'($urandom_range(0, 2));
         c   = $urandom;
         acc = longint'($signed(c));
         ea = {}; eb = {};
         for (int i = 0; i < len; i++) begin
            ea.push_back(8'($urandom));
            eb.push_back(8'($urandom));
            ai = $signed(ea[i]);
            bi = $signed(eb[i]);
            acc += longint'(ai) * longint'(bi);
         end
         run_dot($sformatf("rand%0d", r), c, gap, int'($urandom_range(0, 3)), 1'b0,
                 acc[31:0], (gap == 0) ? 1 + len * (L + 2) : -1);
      end

      // Reset while the first MAC op is in flight; its late result must be ignored.
      begin
         op_t op;
         bit  ok;
         op.a = 8'd3; op.b = 8'd5; op.c = 32'd7;
         exp_ops = {op};
         vec_len = 8'd2; c_init = 32'd7; start = 1'b1;
         @(posedge aclk); #1;
         start = 1'b0;
         feed_one("midop", 8'd3, 8'd5, ok);
         @(posedge aclk); #1;
         aresetn = 1'b0;
         #1;
         check_reset_outputs("midop_reset");
         @(posedge aclk); #1;
         aresetn = 1'b1;
         repeat (L + 2) begin @(posedge aclk); #1; end
         check("midop_late_ignored", {busy, m_axis_dot_tvalid, m_axis_dot_tdata, mac_c_tdata}, 0);
         exp_ops = {};
      end
      ea = {8'd2, 8'd4, 8'd1};
      eb = {8'd3, 8'd5, 8'd1};
      run_dot("after_reset", 32'd10, 0, 0, 1'b0, 32'd37, 1 + 3 * (L + 2));

      // MAC never answers.
      begin
         op_t op;
         bit  ok;
         mac_mute = 1'b1;
         op.a = 8'd5; op.b = 8'd6; op.c = 32'd0;
         exp_ops = {op};
         vec_len = 8'd1; c_init = 32'd0; start = 1'b1;
         @(posedge aclk); #1;
         start = 1'b0;
         feed_one("hung", 8'd5, 8'd6, ok);
         check("hung_issue", mac_a_tvalid, 1);
         @(posedge aclk); #1;
`ifdef MAC_WATCHDOG_EN
         repeat (63) begin @(posedge aclk); #1; end
         check("wd_not_early", {error, busy}, 2'b01);
         @(posedge aclk); #1;
         check("wd_fire", {error, busy}, 2'b11);
         start = 1'b1;
         repeat (10) begin @(posedge aclk); #1; end
         start = 1'b0;
         check("wd_sticky", {error, busy, s_axis_ab_tready}, 3'b110);
`else
         repeat (100) begin @(posedge aclk); #1; end
         check("no_wd_waits", {error, busy, s_axis_ab_tready}, 3'b010);
`endif
         aresetn = 1'b0;
         #1;
         check_reset_outputs("hung_reset");
         @(posedge aclk); #1;
         aresetn  = 1'b1;
         mac_mute = 1'b0;
         exp_ops  = {};
         @(posedge aclk); #1;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Sequences the `fixed_point` multiply-accumulate unit (result = a*b + c) to compute a signed dot product of length `vec_len` over a stream of (a, b) element pairs. The block issues one MAC operation at a time. It feeds each result back as the next c operand and delivers the final accumulator on an output stream. It sits between the matrix-row operand fetch logic and the MAC instance, and owns the MAC's tvalid inputs exclusively.

## Interface
- `A_W`, 8, a operand width (signed)
- `B_W`, 8, b operand width (signed)
- `ACC_W`, 32, c/result/accumulator width (signed)
- `LEN_W`, 8, width of `vec_len`
- `TIMEOUT`, 64, maximum cycles spent in WAIT before the error is raised (watchdog only)
- `aclk` in 1: the single clock; everything is rising-edge
- `aresetn` in 1: asynchronous, active-low reset
- `start` in 1: begin a dot product; sampled only in IDLE
- `vec_len` in LEN_W: element count, latched on an accepted `start`
- `c_init` in ACC_W: initial accumulator (bias), latched on an accepted `start`
- `s_axis_ab_tvalid` in 1, `s_axis_ab_tready` out 1, `s_axis_ab_tdata` in A_W+B_W: element stream, a in [A_W+B_W-1:B_W], b in [B_W-1:0]
- `mac_a_tvalid`, `mac_b_tvalid`, `mac_c_tvalid` out 1: MAC operand valids, always driven identically
- `mac_a_tdata` out A_W, `mac_b_tdata` out B_W, `mac_c_tdata` out ACC_W: MAC operands
- `mac_result_tvalid` in 1, `mac_result_tdata` in ACC_W: MAC result
- `m_axis_dot_tvalid` out 1, `m_axis_dot_tready` in 1, `m_axis_dot_tdata` out ACC_W: final dot product
- `busy` out 1: high in every state except IDLE
- `error` out 1: sticky watchdog flag

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, OUTPUT, ERROR.
- IDLE:
  - `start`=1 latches `vec_len` and `c_init` into acc, and clears count.
  - Goes to FETCH if `vec_len`≠0, else to OUTPUT (result = `c_init`).
- FETCH:
  - `s_axis_ab_tready`=1.
  - On tvalid&tready, latches a/b and goes to ISSUE.
- ISSUE:
  - All three mac tvalids=1 for exactly one cycle, with a/b latched and c=acc.
  - Then goes to WAIT.
- WAIT:
  - On `mac_result_tvalid`, acc←result and count←count+1.
  - Goes to OUTPUT if count+1==vec_len, else to FETCH.
- OUTPUT:
  - `m_axis_dot_tvalid`=1 and tdata=acc, held stable until `m_axis_dot_tready`.
  - After the handshake, goes to IDLE.
- ERROR (watchdog only):
  - `error`=1 and `busy`=1.
  - Leaves only via reset.
- `start` outside IDLE is ignored.
- `mac_result_tvalid` outside WAIT is ignored, and acc is unchanged.
- Arithmetic is done entirely by the MAC. acc is a plain register; there is no saturation and no wrap detection in this block.
- Reset at any point: state=IDLE, acc=0, count=0, and all outputs as listed under Timing. The in-flight MAC result is discarded by the IDLE-ignore rule.

## Timing
- Reset values: `s_axis_ab_tready`=0, all mac tvalids=0, mac tdata=0, `m_axis_dot_tvalid`=0, `m_axis_dot_tdata`=0, `busy`=0, `error`=0.
- All outputs are registered or decoded from state; there is no combinational input→output path except none.
- Per element with the MAC latency L: 1 handshake cycle, 1 ISSUE cycle, then L cycles in WAIT, so each element costs L+2 cycles with zero stall.
- Dot product latency from `start` to `m_axis_dot_tvalid`: 1 + N·(L+2) cycles.
- With `vec_len`=0 the latency is 1 cycle.
- A result and a downstream stall do not interact: acc is frozen in OUTPUT.

## Configuration
- `MAC_WATCHDOG_EN` defined:
  - A counter runs in WAIT and is cleared on entry to WAIT.
  - Reaching `TIMEOUT` moves the FSM to ERROR.
- Not defined:
  - No counter exists, and WAIT waits indefinitely.
  - `error` is tied to 0 and the ERROR state is unreachable.

## Structure
- Shared package `mac_pkg`: the state encoding (3-bit), `A_W`/`B_W`/`ACC_W` defaults, and the packing offsets of `s_axis_ab_tdata`.
- Sub-module `mac_watchdog`: load/enable counter with an expire output, instantiated only under `MAC_WATCHDOG_EN`.

## Test plan
- Basic dot product:
  - Stimulus: MAC model with L=3, signed; `c_init`=10, `vec_len`=3, pairs (2,3),(4,5),(1,1).
  - Required: dot=37; each MAC op issued one at a time with c = the previous result; `busy` drops after the handshake.
- Signed operands:
  - Stimulus: a=8'hFF, b=8'hFF, `c_init`=0, `vec_len`=1.
  - Required: dot=32'h00000001.
- Zero length:
  - Stimulus: `vec_len`=0, `c_init`=32'h1234.
  - Required: dot=32'h1234 one cycle after `start`; no MAC tvalid ever asserted.
- Backpressure:
  - Stimulus: hold `m_axis_dot_tready`=0 for 5 cycles, and gap `s_axis_ab_tvalid` for 4 cycles between elements.
  - Required: tdata stable while stalled; result correct; a spurious `start` during a run is ignored.
- Watchdog (`MAC_WATCHDOG_EN`, `TIMEOUT`=64):
  - Stimulus: MAC model never returns a result.
  - Required: `error`=1 exactly 64 cycles after entry to WAIT; held until `aresetn`.
- Reset mid-operation:
  - Stimulus: assert `aresetn`=0 during WAIT, then let the late MAC result arrive.
  - Required: all outputs return to their reset values; the late result is ignored; a fresh run computes the correct result.
